// File: rtl/fp_cmp_pkg.sv
// rtl/fp_cmp_pkg.sv - shared encodings and width helper for the float comparator
package fp_cmp_pkg;

  localparam logic [2:0] OP_GT  = 3'b000;
  localparam logic [2:0] OP_GE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b010;
  localparam logic [2:0] OP_LE  = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;
  localparam logic [2:0] OP_NE  = 3'b101;
  localparam logic [2:0] OP_MAX = 3'b110;
  localparam logic [2:0] OP_MIN = 3'b111;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  // Full operand width: exception pair + sign + exponent + fraction.
  function automatic int calc_w(input int we, input int wf);
    return we + wf + 3;
  endfunction

endpackage

// File: rtl/fp_mag_cmp.sv
// rtl/fp_mag_cmp.sv - unsigned magnitude compare of exponent/fraction fields
module fp_mag_cmp #(
  parameter int N = 18
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         gt,
  output logic         eq
);

  assign gt = (x > y);
  assign eq = (x == y);

endmodule

// File: rtl/fp_compare_pipe.sv
// rtl/fp_compare_pipe.sv - two-stage float comparator with handshake and unordered counter
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int WE    = 11,
  parameter int WF    = 7,
  parameter int CNT_W = 16,
  localparam int W    = calc_w(WE, WF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag,
  output logic [W-1:0]     res,
  output logic             unordered,
  output logic [CNT_W-1:0] nan_count
);

  localparam int M = WE + WF;
  localparam logic [W-1:0] NAN_CANON = {EXN_NAN, {(W-2){1'b0}}};

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic mag_gt, mag_eq;
  fp_mag_cmp #(.N(M)) u_mag (
    .x  (a[M-1:0]),
    .y  (b[M-1:0]),
    .gt (mag_gt),
    .eq (mag_eq)
  );

  logic         s1_valid;
  logic [2:0]   s1_op;
  logic [W-1:0] s1_a, s1_b;
  logic [1:0]   s1_ca, s1_cb;
  logic         s1_gt, s1_eq;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ca    <= '0;
      s1_cb    <= '0;
      s1_gt    <= 1'b0;
      s1_eq    <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_op    <= op;
      s1_a     <= a;
      s1_b     <= b;
      s1_ca    <= a[W-1 -: 2];
      s1_cb    <= b[W-1 -: 2];
      s1_gt    <= mag_gt;
      s1_eq    <= mag_eq;
    end
  end

  // Position on the real line: -inf, -norm, zero, +norm, +inf.
  function automatic logic [2:0] rank(input logic [1:0] exn, input logic s);
    case (exn)
      EXN_ZERO: rank = 3'd2;
      EXN_NORM: rank = s ? 3'd1 : 3'd3;
      default:  rank = s ? 3'd0 : 3'd4;
    endcase
  endfunction

  logic [2:0]   ra, rb;
  logic         gt, eq, a_nan, b_nan, n_nan, n_flag;
  logic [W-1:0] n_res;

  always_comb begin
    ra    = rank(s1_ca, s1_a[W-3]);
    rb    = rank(s1_cb, s1_b[W-3]);
    gt    = 1'b0;
    eq    = 1'b0;
    if (ra > rb) begin
      gt = 1'b1;
    end else if (ra == rb) begin
      if (ra == 3'd3) begin
        gt = s1_gt;
        eq = s1_eq;
      end else if (ra == 3'd1) begin
        gt = ~s1_gt & ~s1_eq;
        eq = s1_eq;
      end else begin
        eq = 1'b1;
      end
    end

    a_nan  = (s1_ca == EXN_NAN);
    b_nan  = (s1_cb == EXN_NAN);
    n_nan  = a_nan | b_nan;
    n_flag = 1'b0;
    n_res  = '0;
    case (s1_op)
      OP_GT:  n_flag = gt;
      OP_GE:  n_flag = gt | eq;
      OP_LT:  n_flag = ~(gt | eq);
      OP_LE:  n_flag = ~gt;
      OP_EQ:  n_flag = eq;
      OP_NE:  n_flag = ~eq;
      OP_MAX: n_res  = (gt | eq) ? s1_a : s1_b;
      OP_MIN: n_res  = gt ? s1_b : s1_a;
      default: n_flag = 1'b0;
    endcase

    // Unordered pairs: only NE is true; MAX/MIN fall back to the non-NaN side.
    if (n_nan) begin
      n_flag = (s1_op == OP_NE);
      if (s1_op == OP_MAX || s1_op == OP_MIN) begin
        n_res = (a_nan & b_nan) ? NAN_CANON : (a_nan ? s1_b : s1_a);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      flag      <= 1'b0;
      res       <= '0;
      unordered <= 1'b0;
      nan_count <= '0;
    end else begin
      if (en) begin
        out_valid <= s1_valid;
        flag      <= n_flag;
        res       <= n_res;
        unordered <= n_nan;
      end
      if (out_valid && out_ready && unordered && (nan_count != {CNT_W{1'b1}})) begin
        nan_count <= nan_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb/tb_fp_compare_pipe.sv - scoreboard bench for fp_compare_pipe
module tb_fp_compare_pipe;

  localparam int WE    = 11;
  localparam int WF    = 7;
  localparam int CNT_W = 2;
  localparam int W     = WE + WF + 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [W-1:0] ONE  = 21'h09FF80;
  localparam logic [W-1:0] TWO  = 21'h0A0000;
  localparam logic [W-1:0] MONE = 21'h0DFF80;
  localparam logic [W-1:0] PZ   = 21'h000000;
  localparam logic [W-1:0] MZ   = 21'h040000;
  localparam logic [W-1:0] PINF = 21'h100000;
  localparam logic [W-1:0] QNAN = 21'h180000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = '0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             flag;
  logic [W-1:0]     res;
  logic             unordered;
  logic [CNT_W-1:0] nan_count;

  fp_compare_pipe #(.WE(WE), .WF(WF), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flag      (flag),
    .res       (res),
    .unordered (unordered),
    .nan_count (nan_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         flag;
    logic [W-1:0] res;
    logic         unord;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  bit   lat_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Maps an operand onto an integer line so that ordering is plain integer comparison.
  function automatic longint key(input logic [W-1:0] x);
    longint mag;
    mag = longint'(x[WE+WF-1:0]) + 1;
    case (x[W-1:W-2])
      2'b00:   return 0;
      2'b01:   return x[W-3] ? -mag : mag;
      default: return x[W-3] ? -(longint'(1) << 24) : (longint'(1) << 24);
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   r;
    bit     nx, ny;
    longint kx, ky;
    nx = (x[W-1:W-2] == 2'b11);
    ny = (y[W-1:W-2] == 2'b11);
    kx = key(x);
    ky = key(y);
    r.flag = 1'b0; r.res = '0; r.unord = nx | ny; r.cyc = 0; r.lat = 0;
    if (nx || ny) begin
      r.flag = (o == 3'd5);
      if (o >= 3'd6) r.res = (nx && ny) ? QNAN : (nx ? y : x);
    end else begin
      case (o)
        3'd0: r.flag = kx > ky;
        3'd1: r.flag = kx >= ky;
        3'd2: r.flag = kx < ky;
        3'd3: r.flag = kx <= ky;
        3'd4: r.flag = kx == ky;
        3'd5: r.flag = kx != ky;
        3'd6: r.res  = (kx >= ky) ? x : y;
        default: r.res = (kx <= ky) ? x : y;
      endcase
    end
    return r;
  endfunction

  task automatic push(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    r = model(o, x, y);
    r.cyc = cyc;
    r.lat = lat_mode;
    q.push_back(r);
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    logic [1:0]    cls;
    int            sel;
    logic [WE-1:0] ex;
    logic [WF-1:0] fr;
    sel = $urandom_range(0, 9);
    cls = (sel < 2) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
    ex  = ($urandom_range(0, 1) == 1) ? WE'($urandom_range(1022, 1023)) : WE'($urandom);
    fr  = ($urandom_range(0, 1) == 1) ? WF'($urandom_range(0, 1)) : WF'($urandom);
    return {cls, 1'($urandom), ex, fr};
  endfunction

  // Scoreboard monitor: compares every delivered result against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      exp_cnt = 0;
    end else if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: actual res %0h flag %0b required no output", res, flag);
      end else begin
        e = q.pop_front();
        chk("flag", 32'(flag), 32'(e.flag));
        chk("res", 32'(res), 32'(e.res));
        chk("unordered", 32'(unordered), 32'(e.unord));
        chk("nan_count", 32'(nan_count), 32'(exp_cnt));
        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
        if (e.unord && exp_cnt < CMAX) exp_cnt = exp_cnt + 1;
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
      @(negedge clk);
      if (in_ready && rst) begin
        push(o, x, y);
        done = 1;
      end
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: actual not accepted required accepted");
    end
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: actual %0d pending required 0", q.size());
    end
    @(posedge clk);
    @(negedge clk);
    chk("nan_count_settled", 32'(nan_count), 32'(exp_cnt));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_nan_count", 32'(nan_count), 32'd0);
  endtask

  logic [2:0]   dir_op[9] = '{3'd0, 3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd5, 3'd7, 3'd6};
  logic [W-1:0] dir_a[9]  = '{TWO, ONE, MONE, PZ, PZ, PINF, QNAN, QNAN, QNAN};
  logic [W-1:0] dir_b[9]  = '{ONE, TWO, PZ, MZ, MZ, TWO, ONE, MONE, QNAN};

  initial begin
    logic [W-1:0] snap_res;
    logic         snap_flag;
    logic [2:0]   bp_op[4];
    logic [W-1:0] bp_a[4], bp_b[4];
    int           k;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_flag", 32'(flag), 32'd0);
    chk("reset_res", 32'(res), 32'd0);
    chk("reset_unordered", 32'(unordered), 32'd0);
    chk("reset_nan_count", 32'(nan_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    lat_mode = 1;
    for (int i = 0; i < 9; i++) send(dir_op[i], dir_a[i], dir_b[i]);
    drain();
    lat_mode = 0;

    // Backpressure: four pairs with the output stalled for five cycles.
    for (int i = 0; i < 4; i++) begin
      bp_op[i] = 3'($urandom);
      bp_a[i]  = rnd_opnd();
      bp_b[i]  = rnd_opnd();
    end
    k = 0;
    snap_res = '0;
    snap_flag = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = bp_op[k]; a = bp_a[k]; b = bp_b[k]; out_ready = 1'b0;
      @(negedge clk);
      if (c >= 2) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        if (c == 2) begin
          snap_res = res;
          snap_flag = flag;
        end else begin
          chk("bp_res_stable", 32'(res), 32'(snap_res));
          chk("bp_flag_stable", 32'(flag), 32'(snap_flag));
        end
      end
      if (in_ready) begin
        push(bp_op[k], bp_a[k], bp_b[k]);
        k++;
      end
    end
    while (k < 4) begin
      send(bp_op[k], bp_a[k], bp_b[k]);
      k++;
    end
    drain();

    // Counter saturation from a cleared count, with non-NaN results interleaved.
    pulse_reset();
    send(3'd5, QNAN, ONE);
    send(3'd0, TWO, ONE);
    send(3'd7, QNAN, MONE);
    send(3'd6, QNAN, QNAN);
    send(3'd4, PZ, MZ);
    send(3'd2, ONE, QNAN);
    send(3'd3, QNAN, PINF);
    drain();
    chk("nan_count_saturated", 32'(nan_count), CMAX);

    // Reset with two pairs in flight; nothing stale may emerge.
    send(3'd6, rnd_opnd(), rnd_opnd());
    send(3'd1, rnd_opnd(), rnd_opnd());
    pulse_reset();
    repeat (4) @(negedge clk);
    drain();

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 3'($urandom);
      a         = rnd_opnd();
      b         = ($urandom_range(0, 9) == 0) ? a : rnd_opnd();
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready && rst) push(op, a, b);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_compare_pipe.md
# fp_compare_pipe

Parametrised, pipelined comparator for the FloPoCo-format floats used across the ray/AABB datapath. It compares two operands in one of eight modes (relational, equality, max/min) and handles the exception classes zero, infinity and NaN explicitly. It replaces the subtract-and-test-sign comparators in the slab-test stages, and adds a valid/ready handshake and an unordered-event counter.

## Interface
- WE, 11, exponent width
- WF, 7, fraction width
- CNT_W, 16, width of the unordered-event counter
- Derived localparam W = WE+WF+3. Operand layout, MSB first: exn[1:0] (00 zero, 01 normal, 10 inf, 11 NaN), sign, exponent[WE-1:0], fraction[WF-1:0].

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts the pair this cycle
- op  in  3  mode: 000 GT, 001 GE, 010 LT, 011 LE, 100 EQ, 101 NE, 110 MAX, 111 MIN
- a, b  in  W  operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- flag  out  1  predicate result; 0 for MAX/MIN
- res  out  W  selected operand for MAX/MIN; all-zero for predicate modes
- unordered  out  1  at least one operand is NaN
- nan_count  out  CNT_W  saturating count of delivered results with unordered=1

## Operation
- Stage S1: registers op, a and b, and these precomputed terms:
  - the class of each operand
  - mag_gt = (a.exp,a.frac) > (b.exp,b.frac), unsigned
  - mag_eq = (a.exp,a.frac) == (b.exp,b.frac)
- Stage S2: resolves the signed ordering and the mode, then registers flag, res and unordered.
- Ordering rules:
  - Zero, sign ignored: +0 == -0.
  - ±inf lies beyond every normal on its side; +inf == +inf.
  - Normals: a positive value is above any negative value. With the same sign, magnitude order applies, reversed when both are negative.
  - Zero lies between the negative and the positive normals.
- NaN handling (either operand NaN):
  - unordered=1.
  - flag=0 in every mode except NE, where flag=1.
  - MAX/MIN return the non-NaN operand. If both are NaN, res = {2'b11, {(W-2){1'b0}}}.
- MAX/MIN tie (equal values, including ±0): return a.
- nan_count increments by 1 on each output handshake (out_valid & out_ready) carrying unordered=1. It saturates at all-ones and never wraps.

## Timing
- Pipeline enable: en = out_ready | ~out_valid; in_ready = en (combinational).
- When en=1, both stages advance together. S1 valid <= in_valid; S2 valid <= S1 valid. When en=0, all stage registers hold.
- Latency is exactly 2 cycles from accept (in_valid & in_ready) to out_valid, when out_ready stays high. Throughput is 1 pair per cycle.
- While stalled, out_valid, flag, res and unordered hold stable until they are accepted.
- Reset (rst=0 at a rising edge), all values 0:
  - both stage valid bits, so out_valid=0
  - flag, res, unordered
  - nan_count
- Reset mid-operation discards in-flight pairs; none reappear afterwards.
- in_ready may be 1 during reset. Pairs presented while rst=0 are dropped.
- A bubble in S1 with a stalled S2 is not collapsed. This is accepted behaviour.

## Structure
- Package fp_cmp_pkg holds:
  - op encodings (localparams OP_GT … OP_MIN)
  - exception-class constants EXN_ZERO, EXN_NORM, EXN_INF, EXN_NAN
  - a function that computes W from WE and WF
- One sub-module, fp_mag_cmp: parametrised unsigned magnitude compare of WE+WF bits producing gt/eq. It sits in S1 and can be split into high/low halves if timing requires.

## Test plan
With WE=11, WF=7: 1.0=0x09FF80, 2.0=0x0A0000, -1.0=0x0DFF80, +0=0x000000, -0=0x040000, +inf=0x100000, NaN=0x180000.
1. Reset release, then GT a=2.0 b=1.0, back-to-back with GT a=1.0 b=2.0 → out_valid at cycles +2 and +3; flag 1 then 0.
2. Sign and zero: LT a=-1.0 b=+0 → flag=1; EQ a=+0 b=-0 → flag=1; MAX a=+0 b=-0 → res=0x000000.
3. Infinity and NaN:
   - GE a=+inf b=2.0 → flag=1.
   - NE a=NaN b=1.0 → flag=1, unordered=1.
   - MIN a=NaN b=-1.0 → res=0x0DFF80.
   - MAX a=NaN b=NaN → res=0x180000.
4. Backpressure: stream 4 pairs with out_ready held 0 for 5 cycles → in_ready=0 once both stages are full; outputs stay stable; all 4 results arrive in order with none lost or duplicated.
5. Counter: CNT_W=2, deliver 5 NaN results → nan_count goes 1, 2, 3, 3, 3. Non-NaN results leave it unchanged.
6. Drive rst=0 for one cycle with 2 pairs in flight → out_valid=0 and nan_count=0 next cycle; no stale result emerges afterwards.
